somador_serial_ctrl: RTL
========================

# somador_serial_ctrl

Bit-serial adder controller that time-shares a single 1-bit full-adder cell to add two N-bit operands over N clock cycles. It sits beside the combinational adder cells in the lab datapath as their sequencer. It latches operands on a start request, feeds one bit pair per cycle through the shared cell, and shifts the sum into a result register. A start/busy/done handshake tells the surrounding logic when the result is valid.

## Interface
- N, 8: operand and result width in bits; N ≥ 2.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only in IDLE or FIM.
- a  input  N  operand A, sampled on the accepting edge.
- b  input  N  operand B, sampled on the accepting edge.
- sub  input  1  subtract request; exists only with SOMADOR_SERIAL_SUB_EN; sampled with a/b.
- busy  output  1  high while bits are being processed (state SOMA).
- done  output  1  one-cycle pulse; soma/cout valid in that cycle.
- soma  output  N  result; holds its value until the next accepted start.
- cout  output  1  final carry out; held like soma.

## Operation
- States: IDLE, SOMA, FIM.
- IDLE→SOMA: start=1 at an edge.
  - Load shift registers ra←a, rb←b.
  - Set carry←0 and count←0; clear soma and cout.
- SOMA, each edge:
  - Full-adder cell computes s, c from ra[0], rb[0], carry.
  - soma←{s, soma[N-1:1]}; carry←c.
  - ra and rb shift right by 1; count←count+1.
- SOMA→FIM: on the edge that processes bit N-1, i.e. count==N-1 before that edge.
  - cout←c on that edge.
- FIM: done=1 for this cycle only.
  - start=1 → SOMA with a fresh load (back-to-back).
  - start=0 → IDLE.
- start is ignored in SOMA. Operands are not re-sampled during an operation.
- Arithmetic:
  - soma = (a+b) mod 2^N.
  - cout = bit N of a+b (unsigned).
  - Counter width is $clog2(N)+1; count never wraps during an operation.
- Reset asserted at any time, including mid-operation:
  - State→IDLE.
  - busy=0, done=0, soma=0, cout=0; ra, rb, carry and count cleared.
  - An operation interrupted by reset is abandoned with no done pulse.

## Timing
- Reset values: busy=0, done=0, soma=0, cout=0.
- Start accepted at edge k:
  - busy=1 from after edge k through after edge k+N-1 (N cycles).
  - done=1 in the cycle after edge k+N.
  - Latency from the accepting edge to done is N+1 edges.
- Throughput: one operation per N+1 cycles when start is held high.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Configuration
- SOMADOR_SERIAL_SUB_EN defined:
  - The sub port exists.
  - If sub=1 at the accepting edge: load rb←~b and carry←1, so soma=(a−b) mod 2^N and cout=1 iff a≥b (no borrow).
  - sub=0 behaves as addition.
- Not defined: the sub port is absent and the block is add-only.

## Structure
- Package somador_pkg holds:
  - The state enum typedef (IDLE, SOMA, FIM).
  - Default width constant SOMADOR_N=8.
- One sub-module, somador_completo: the 1-bit full adder built from two half adders plus OR, instantiated once as the shared cell. It has no state.

## Test plan
All scenarios use N=8.
- Reset, then idle with start=0 → busy=0, done=0, soma=0x00, cout=0 for 20 cycles.
- a=0x0F, b=0x01, start pulse → busy high 8 cycles, done after 9 edges, soma=0x10, cout=0; soma holds afterwards.
- a=0xFF, b=0x01 → soma=0x00, cout=1. a=0xAA, b=0x55 → soma=0xFF, cout=0.
- Start and new operands applied during SOMA → ignored; result equals the first operation's sum. Start held high through FIM → next operation begins immediately, done pulses every 9 cycles.
- rst_n dropped at cycle 4 of an operation → outputs zero immediately (asynchronous); no done pulse; next start works normally.
- With SOMADOR_SERIAL_SUB_EN: a=0x05, b=0x07, sub=1 → soma=0xFE, cout=0. a=0x07, b=0x05, sub=1 → soma=0x02, cout=1.

Source files
------------

// File: rtl/somador_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package somador_pkg;

    localparam int SOMADOR_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOMA = 2'd1,
        FIM  = 2'd2
    } estado_t;

endpackage

// File: rtl/somador_completo.sv
// 1-bit full adder built from two half adders and an OR; purely combinational.
module somador_completo (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    assign s1   = a ^ b;
    assign c1   = a & b;
    assign s    = s1 ^ cin;
    assign c2   = s1 & cin;
    assign cout = c1 | c2;

endmodule

// File: rtl/somador_serial_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell, N cycles per operation.
// Optional subtraction support is compiled in with SOMADOR_SERIAL_SUB_EN.
module somador_serial_ctrl
    import somador_pkg::*;
#(
    parameter int N = SOMADOR_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
`ifdef SOMADOR_SERIAL_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] soma,
    output logic         cout
);

    localparam int CW = $clog2(N) + 1;

    estado_t       state_q;
    estado_t       state_d;
    logic [N-1:0]  ra_q;
    logic [N-1:0]  rb_q;
    logic [N-1:0]  soma_q;
    logic          carry_q;
    logic          cout_q;
    logic          busy_q;
    logic          done_q;
    logic [CW-1:0] count_q;

    logic          accept;
    logic          last_bit;
    logic          fa_s;
    logic          fa_c;
    logic [N-1:0]  b_load;
    logic          cin_load;

    // Subtraction is a + ~b + 1: invert B on load and seed the carry.
`ifdef SOMADOR_SERIAL_SUB_EN
    assign b_load   = sub ? ~b : b;
    assign cin_load = sub;
`else
    assign b_load   = b;
    assign cin_load = 1'b0;
`endif

    assign accept   = start && ((state_q == IDLE) || (state_q == FIM));
    assign last_bit = (state_q == SOMA) && (count_q == CW'(N - 1));

    somador_completo u_fa (
        .a    (ra_q[0]),
        .b    (rb_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = SOMA;
            SOMA: if (last_bit) state_d = FIM;
            FIM:  state_d = start ? SOMA : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // busy/done are decoded from the next state so both leave flops directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_d == SOMA);
            done_q <= (state_d == FIM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_q    <= '0;
            rb_q    <= '0;
            soma_q  <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            count_q <= '0;
        end else if (accept) begin
            ra_q    <= a;
            rb_q    <= b_load;
            soma_q  <= '0;
            carry_q <= cin_load;
            cout_q  <= 1'b0;
            count_q <= '0;
        end else if (state_q == SOMA) begin
            soma_q  <= {fa_s, soma_q[N-1:1]};
            carry_q <= fa_c;
            ra_q    <= ra_q >> 1;
            rb_q    <= rb_q >> 1;
            count_q <= count_q + CW'(1);
            if (last_bit) begin
                cout_q <= fa_c;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign soma = soma_q;
    assign cout = cout_q;

endmodule
